// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one FU result granted per cycle,
// broadcast from a register one cycle later, with a saturating contention counter.
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [SRC_W-1:0]        cdb_src,
    output logic [CNT_W-1:0]        conflict_cnt
);

    logic [SRC_W-1:0]  rr_ptr_q,       rr_ptr_d;
    logic              cdb_valid_q,    cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,      cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q,     cdb_data_d;
    logic [SRC_W-1:0]  cdb_src_q,      cdb_src_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

    logic              grant_vld;
    logic [SRC_W-1:0]  grant_idx;
    logic              multi_req;

    // Walk offsets from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        if (reset && !flush) begin
            for (int j = N_REQ - 1; j >= 0; j--) begin
                idx = int'(rr_ptr_q) + j;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (req_valid[idx] == 1'b1) begin
                    grant_vld = 1'b1;
                    grant_idx = SRC_W'(idx);
                end
            end
            if (grant_vld) req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        int n_valid;
        n_valid = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] == 1'b1) n_valid = n_valid + 1;
        end
        multi_req = (n_valid >= 2);
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        cdb_valid_d    = 1'b0;
        cdb_tag_d      = cdb_tag_q;
        cdb_data_d     = cdb_data_q;
        cdb_src_d      = cdb_src_q;
        conflict_cnt_d = conflict_cnt_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else begin
            if (multi_req && (conflict_cnt_q != {CNT_W{1'b1}}))
                conflict_cnt_d = conflict_cnt_q + 1'b1;
            if (grant_vld) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = req_tag[int'(grant_idx)*TAG_W +: TAG_W];
                cdb_data_d  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
                cdb_src_d   = grant_idx;
                rr_ptr_d    = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q       <= '0;
            cdb_valid_q    <= 1'b0;
            cdb_tag_q      <= '0;
            cdb_data_q     <= '0;
            cdb_src_q      <= '0;
            conflict_cnt_q <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            cdb_valid_q    <= cdb_valid_d;
            cdb_tag_q      <= cdb_tag_d;
            cdb_data_q     <= cdb_data_d;
            cdb_src_q      <= cdb_src_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_tag      = cdb_tag_q;
    assign cdb_data     = cdb_data_q;
    assign cdb_src      = cdb_src_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule
